// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the execution-stage multiply/divide unit.
//   md_op_e    : operation code, numbered as the RISC-V M-extension funct3
//   md_state_e : control FSM states of ex_muldiv_unit
// Helper functions decode operation classes from md_op_e.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Every divide/remainder op has funct3[2] set.
  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic md_a_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_md_iter_step.sv
// md_iter_step: combinational datapath for one iteration of the iterative
// multiply/divide unit. Performs STEP_BITS shift-add steps (multiply) or
// STEP_BITS restoring-subtract steps (divide).
//   is_div_i : 1 selects restoring divide, 0 selects shift-add multiply
//   hi_i/lo_i: accumulator halves in (multiply: product hi / multiplier+product lo;
//              divide: partial remainder / dividend+quotient)
//   opb_i    : multiplicand (multiply) or divisor (divide)
//   hi_o/lo_o: accumulator halves after STEP_BITS steps
module md_iter_step #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_v;
  logic [XLEN-1:0] lo_v;
  logic [XLEN:0]   wide_v;

  always_comb begin
    hi_v   = hi_i;
    lo_v   = lo_i;
    wide_v = '0;
    for (int s = 0; s < int'(STEP_BITS); s++) begin
      if (is_div_i) begin
        // Shift the next dividend bit into the remainder; one extra bit is
        // needed because the shifted remainder can reach 2*divisor-1.
        wide_v = {hi_v, lo_v[XLEN-1]};
        lo_v   = {lo_v[XLEN-2:0], 1'b0};
        if (wide_v >= {1'b0, opb_i}) begin
          wide_v  = wide_v - {1'b0, opb_i};
          lo_v[0] = 1'b1;
        end
        hi_v = wide_v[XLEN-1:0];
      end else begin
        // Conditionally add the multiplicand, then shift the whole product
        // right with the carry entering the top.
        wide_v = {1'b0, hi_v} + (lo_v[0] ? {1'b0, opb_i} : {(XLEN+1){1'b0}});
        lo_v   = {wide_v[0], lo_v[XLEN-1:1]};
        hi_v   = wide_v[XLEN:1];
      end
    end
    hi_o = hi_v;
    lo_o = lo_v;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready
// handshake, flush and single-cycle divide corner-case fast paths.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   valid_i / ready_o   : request handshake (ready only in IDLE)
//   op_i, a_i, b_i      : funct3-encoded operation and operands
//   kill_i              : flush, returns to IDLE and suppresses valid_o
//   stall_o             : hold request to the hazard unit
//   valid_o, result_o   : one-cycle result strobe, result held until next accept
//
// state | meaning
// IDLE  | waiting for a request, ready_o high
// BUSY  | iterating, counter counts ITER down to 1
// FIX   | sign correction and product half / quotient-remainder select
// DONE  | valid_o high for one cycle
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned ITER = XLEN / STEP_BITS;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  if (((XLEN % STEP_BITS) != 0) ||
      !((STEP_BITS == 1) || (STEP_BITS == 2) || (STEP_BITS == 4) || (STEP_BITS == 8)))
  begin : g_param_check
    $error("ex_muldiv_unit: XLEN must be a multiple of STEP_BITS and STEP_BITS in {1,2,4,8}");
  end

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  md_op_e          op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  // Request decode
  md_op_e          op_in;
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] int_min;

  assign op_in   = md_op_e'(op_i);
  assign accept  = valid_i && (state_q == MD_IDLE) && !kill_i;
  assign int_min = {1'b1, {(XLEN-1){1'b0}}};

  assign a_neg = md_a_signed(op_in) && a_i[XLEN-1];
  assign b_neg = md_b_signed(op_in) && b_i[XLEN-1];
  assign a_abs = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_abs = b_neg ? (~b_i + 1'b1) : b_i;

  assign div_zero = md_is_div(op_in) && (b_i == '0);
  assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (a_i == int_min) && (b_i == '1);

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = md_is_rem(op_in) ? a_i : '1;
    end else if (op_in == MD_DIV) begin
      fast_res = a_i;
    end
  end

  // Iteration datapath
  logic [XLEN-1:0] step_hi, step_lo;

  md_iter_step #(
    .XLEN      (XLEN),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .is_div_i (md_is_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sign fix and result select
  logic [2*XLEN-1:0] prod_v;
  logic [XLEN-1:0]   quo_v, rem_v;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_v  = {hi_q, lo_q};
    quo_v   = lo_q;
    rem_v   = hi_q;
    fix_res = '0;
    if (neg_q) begin
      prod_v = ~prod_v + 1'b1;
      quo_v  = ~quo_v + 1'b1;
      rem_v  = ~rem_v + 1'b1;
    end
    if (md_is_div(op_q)) begin
      fix_res = md_is_rem(op_q) ? rem_v : quo_v;
    end else begin
      fix_res = (op_q == MD_MUL) ? prod_v[XLEN-1:0] : prod_v[2*XLEN-1:XLEN];
    end
  end

  // FSM next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d = op_in;
          // Remainder follows the dividend; quotient and product follow a^b.
          neg_d = (op_in == MD_REM) ? a_neg : (a_neg ^ b_neg);
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = MD_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = md_is_div(op_in) ? a_abs : b_abs;
            opb_d   = md_is_div(op_in) ? b_abs : a_abs;
            cnt_d   = ITER_C;
            state_d = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        result_d = fix_res;
        state_d  = MD_DONE;
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase

    if (kill_i) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = (state_q == MD_DONE) && !kill_i;
  assign stall_o  = (valid_i && (state_q == MD_IDLE) && !kill_i) ||
                    (state_q == MD_BUSY) || (state_q == MD_FIX);
  assign result_o = result_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised iterative multiply/divide unit for the execution stage. It implements all eight RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over configurable XLEN and configurable bits retired per cycle. It sits beside the single-cycle ALU and drives the execution-stage stall while busy. It adds a valid/ready handshake, a flush (kill) path and single-cycle fast paths for the architectural divide corner cases.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be a multiple of STEP_BITS.
- STEP_BITS, 1, quotient/multiplier bits retired per iteration; legal values 1, 2, 4, 8.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- valid_i  in  1  request valid; operands and op sampled only on accept.
- ready_o  out  1  high only in IDLE.
- op_i  in  3  md_op_e, encoded as RISC-V funct3 (0 MUL … 7 REMU).
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- kill_i  in  1  flush; aborts any operation in progress.
- stall_o  out  1  hold request to hazard unit.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result; held until the next accept.

## Operation
- Accept: valid_i && ready_o && !kill_i.
- States (md_state_e):
  - IDLE
  - BUSY: ITER = XLEN/STEP_BITS cycles, counter counts down.
  - FIX: sign correction and half select.
  - DONE: valid_o=1 for one cycle, then IDLE.
- Accept captures absolute values of the signed operands, the result-sign flags and op. Signedness:
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
- Multiply: shift-add into a 2·XLEN product register.
  - MUL selects the low half.
  - MULH/MULHSU/MULHU select the high half.
  - Negation is applied to the full 2·XLEN product in FIX.
- Divide: restoring, STEP_BITS stages per cycle.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Fast path: the accept cycle goes straight to DONE.
  - Divide by zero: DIV/DIVU result = all-ones; REM/REMU result = a_i.
  - Signed overflow (DIV/REM, a = −2^(XLEN−1), b = −1): DIV result = a_i; REM result = 0.
- kill_i:
  - In any state, the next state is IDLE.
  - valid_o is suppressed, including in DONE.
  - result_o is unchanged.
  - kill_i wins over a same-cycle accept.
- stall_o = (valid_i && IDLE && !kill_i) || BUSY || FIX. It is low in DONE so the pipeline advances while valid_o is high.

## Timing
- Reset values:
  - State IDLE, ready_o=1, valid_o=0, result_o=0, counter=0.
  - stall_o=0 while valid_i=0.
- Normal latency: the accept edge is cycle 0; valid_o is high in cycle ITER+2 (XLEN=32: STEP_BITS=1 → 34, STEP_BITS=4 → 10).
- Fast-path latency: valid_o is high in cycle 1.
- Back-to-back: a new accept is possible in the cycle after DONE, giving a throughput of one op per ITER+3 cycles.
- result_o updates on the edge that enters DONE. It is stable while valid_o is high and after it.
- Reset asserted mid-operation: outputs go to their reset values immediately; no valid_o follows.
- Counter width is clog2(ITER+1). There is no wrap: BUSY exits when the counter reaches 1.

## Structure
- tcore_param package additions:
  - md_op_e (MUL=0 … REMU=7).
  - md_state_e (IDLE, BUSY, FIX, DONE).
- Elaboration-time assertion: XLEN % STEP_BITS == 0 and STEP_BITS ∈ {1,2,4,8}.
- Sub-module md_iter_step: combinational, one iteration. It performs STEP_BITS shift-add steps or STEP_BITS restoring-subtract steps, selected by an is_div input. The top module holds the FSM, the operand/accumulator registers and the sign-fix logic.

## Test plan
- MUL a=0xFFFFFFFF, b=2 → result 0xFFFFFFFE; valid_o in cycle 34 (STEP_BITS=1). MULH with the same operands → 0xFFFFFFFF. MULHU with the same operands → 0x00000001.
- DIV a=−7, b=2 → 0xFFFFFFFD (−3). REM a=−7, b=2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF, valid_o in cycle 1. REM a=0x80000000, b=0xFFFFFFFF → 0, valid_o in cycle 1.
- MULHSU a=−1, b=0xFFFFFFFF → 0xFFFFFFFF. Repeat with STEP_BITS=4 and check valid_o in cycle 10.
- kill_i asserted in BUSY cycle 5 → IDLE next cycle, ready_o=1, no valid_o, result_o keeps its prior value. A new DIVU 9/3 accepted afterwards → 3.
- rst_ni pulled low mid-BUSY → valid_o=0, result_o=0, ready_o=1 immediately. After release, no spurious valid_o.
